extended_hamming_stream_encoder: RTL and testbench
==================================================

# extended_hamming_stream_encoder

Streaming, multi-lane extended Hamming (SECDED) encoder. Accepts data words over a valid/ready handshake, computes the extended Hamming code for each lane, and packs data and code into protected blocks. Blocks are delivered through a registered output stage with a skid buffer, so throughput is one beat per cycle. The block sits on the write path of ECC-protected memories and links, ahead of storage or serialisation, and supports error injection for decoder verification.

## Interface
- DATA_WIDTH, 8, data bits per lane (≥1)
- LANE_COUNT, 1, independent lanes per beat (≥1)
- PARITY_WIDTH, localparam, extended Hamming parity width for DATA_WIDTH (Hamming bits + 1); 5 for DATA_WIDTH=8
- BLOCK_WIDTH, localparam, DATA_WIDTH + PARITY_WIDTH; 13 for DATA_WIDTH=8
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- data_valid  in  1  input beat valid
- data_ready  out  1  input beat accepted when data_valid && data_ready
- data  in  LANE_COUNT*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- inject_single  in  1  sampled with input beat; flip block bit 1 of lane 0
- inject_double  in  1  sampled with input beat; flip block bits 1 and 2 of lane 0
- block_valid  out  1  output beat valid
- block_ready  in  1  output beat consumed when block_valid && block_ready
- block  out  LANE_COUNT*BLOCK_WIDTH  lane i at [i*BLOCK_WIDTH +: BLOCK_WIDTH]

## Operation
- Per lane: Hamming positions numbered from 1; parity bits at power-of-two positions, data bits fill remaining positions in ascending order (data bit 0 at position 3). Parity bit at position 2^k = XOR of all data bits whose position has bit k set.
- Extra parity = XOR of all data and Hamming parity bits (even parity over the full block).
- Block packing: bit 0 = extra parity; bit p (p ≥ 1) = Hamming position p.
- Injection applied after encoding, lane 0 only. inject_double has priority over inject_single. Injection affects only the beat it is sampled with.
- Buffering: one output register plus one skid register, two beats maximum in flight.
- data_ready = !skid_valid, registered; not combinationally dependent on block_ready.
- On accept: if output register empty or being consumed this cycle, the beat is written to the output register; otherwise it is written to the skid register.
- On output consume with skid full: skid moves to output register, skid becomes empty.
- Simultaneous accept and consume with skid empty: the new beat replaces the output register, and block_valid stays 1.
- block and block_valid must be held stable while block_valid && !block_ready.

## Timing
- Latency: beat accepted at edge N appears on block with block_valid=1 after edge N (one cycle).
- Throughput: one beat per cycle with block_ready held at 1.
- Reset values: block_valid=0, data_ready=1, block=0, skid empty. Reset is asynchronous on assertion; any in-flight beats are dropped.
- Reset mid-stream: all beats accepted before reset are lost. The first beat after reset deasserts is treated as fresh.
- Full condition: output and skid both valid gives data_ready=0 on the following cycle. data_valid while full is ignored, with no state change.
- Empty condition: block_valid=0; block holds its last value or reset value, and is don't-care to consumers.

## Structure
- Shared package: function returning extended parity width for a data width, Hamming position-to-data-index helper, BLOCK_WIDTH derivation. These are reused by the matching decoder.
- Sub-module: extended_hamming_encoder (combinational, one DATA_WIDTH lane → PARITY_WIDTH code, extra parity at bit 0), instantiated LANE_COUNT times. Packing uses the existing extended_hamming_block_packer per lane.
- Top module contains the injection logic, output register, skid register and handshake control.

## Test plan
- DATA_WIDTH=8, LANE_COUNT=1, block_ready=1: data 0x00 → block 0x0000; 0x01 → 0x000F; 0xFF → 0x1EEE. Each appears one cycle after accept.
- LANE_COUNT=2, data {0xFF,0x01} → block {0x1EEE,0x000F}. Lanes are independent.
- Injection: data 0x01 with inject_single → 0x000D; with inject_double → 0x0009; with both → 0x0009. The next beat is clean.
- Backpressure: block_ready=0, stream 0x01, 0x02, 0x03. The first two are accepted and data_ready drops. Then release block_ready: output order is 0x01, 0x02, 0x03 with no loss or duplicate, and block is stable while stalled.
- Full-rate random stream of 1000 beats with random block_ready. A scoreboard confirms every block decodes with a zero syndrome and even overall parity, in order.
- Assert reset with two beats buffered: block_valid=0 and data_ready=1 immediately. After deassertion, a fresh beat 0xFF → 0x1EEE.

Source files
------------

// File: rtl/extended_hamming_stream_encoder_pkg.sv
// Shared helpers for the extended Hamming (SECDED) encoder and its matching decoder:
// parity-width derivation, block-width derivation and Hamming position to data-index mapping.
package extended_hamming_stream_encoder_pkg;

  // Block bits flipped by the error-injection controls (lane 0 only).
  localparam int INJ_BIT_A = 1;
  localparam int INJ_BIT_B = 2;

  // Smallest r with 2^r >= data_width + r + 1.
  function automatic int hamming_bits(input int data_width);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < data_width + r + 1) r = r + 1;
    end
    return r;
  endfunction

  function automatic int ext_parity_width(input int data_width);
    return hamming_bits(data_width) + 1;
  endfunction

  function automatic int block_width(input int data_width);
    return data_width + ext_parity_width(data_width);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Data index carried at a non-power-of-two Hamming position.
  function automatic int pos_to_data_idx(input int pos);
    int n_par;
    n_par = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) <= pos) n_par = n_par + 1;
    end
    return pos - 1 - n_par;
  endfunction

endpackage

// File: rtl/extended_hamming_block_packer.sv
// Packs one lane's data and extended code into a block: bit 0 = overall parity,
// bit p = Hamming position p.
module extended_hamming_block_packer
  import extended_hamming_stream_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int PARITY_WIDTH = ext_parity_width(DATA_WIDTH),
  localparam int BLOCK_WIDTH  = block_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [PARITY_WIDTH-1:0] code,
  output logic [BLOCK_WIDTH-1:0]  block
);

  assign block[0] = code[0];

  genvar p;
  for (p = 1; p < BLOCK_WIDTH; p = p + 1) begin : g_pos
    if (is_pow2(p)) begin : g_par
      assign block[p] = code[$clog2(p) + 1];
    end else begin : g_dat
      assign block[p] = data[pos_to_data_idx(p)];
    end
  end

endmodule

// File: rtl/extended_hamming_encoder.sv
// Combinational extended Hamming code for one lane: code[0] = overall parity,
// code[k+1] = Hamming parity for position 2^k.
module extended_hamming_encoder
  import extended_hamming_stream_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int PARITY_WIDTH = ext_parity_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [PARITY_WIDTH-1:0] code
);

  localparam int HAM_BITS = PARITY_WIDTH - 1;
  localparam int TOP_POS  = DATA_WIDTH + HAM_BITS;

  // Data bits laid out at their Hamming positions; parity slots read as zero.
  logic [TOP_POS:1]    pos_vec;
  logic [HAM_BITS-1:0] ham;

  genvar p;
  for (p = 1; p <= TOP_POS; p = p + 1) begin : g_pos
    if (is_pow2(p)) begin : g_par
      assign pos_vec[p] = 1'b0;
    end else begin : g_dat
      assign pos_vec[p] = data[pos_to_data_idx(p)];
    end
  end

  always_comb begin
    ham = '0;
    for (int k = 0; k < HAM_BITS; k++) begin
      for (int q = 1; q <= TOP_POS; q++) begin
        if (((q >> k) & 1) != 0) ham[k] = ham[k] ^ pos_vec[q];
      end
    end
  end

  assign code = {ham, ^{data, ham}};

endmodule

// File: rtl/extended_hamming_stream_encoder.sv
// Multi-lane SECDED stream encoder with lane-0 error injection; 1-cycle latency.
// Output register plus skid register; data_ready is registered (!skid valid), never combinational on block_ready.
module extended_hamming_stream_encoder
  import extended_hamming_stream_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_COUNT = 1,
  localparam int PARITY_WIDTH = ext_parity_width(DATA_WIDTH),
  localparam int BLOCK_WIDTH  = block_width(DATA_WIDTH)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             data_valid,
  output logic                             data_ready,
  input  logic [LANE_COUNT*DATA_WIDTH-1:0] data,
  input  logic                             inject_single,
  input  logic                             inject_double,
  output logic                             block_valid,
  input  logic                             block_ready,
  output logic [LANE_COUNT*BLOCK_WIDTH-1:0] block
);

  localparam int BUS_W = LANE_COUNT * BLOCK_WIDTH;

  logic [BUS_W-1:0] enc_blocks;
  logic [BUS_W-1:0] inj_mask;
  logic [BUS_W-1:0] beat_dat;

  genvar i;
  for (i = 0; i < LANE_COUNT; i = i + 1) begin : g_lane
    logic [PARITY_WIDTH-1:0] code;

    extended_hamming_encoder #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
      .data (data[i*DATA_WIDTH +: DATA_WIDTH]),
      .code (code)
    );

    extended_hamming_block_packer #(.DATA_WIDTH(DATA_WIDTH)) u_pack (
      .data  (data[i*DATA_WIDTH +: DATA_WIDTH]),
      .code  (code),
      .block (enc_blocks[i*BLOCK_WIDTH +: BLOCK_WIDTH])
    );
  end

  always_comb begin
    inj_mask = '0;
    if (inject_double) begin
      inj_mask[INJ_BIT_A] = 1'b1;
      inj_mask[INJ_BIT_B] = 1'b1;
    end else if (inject_single) begin
      inj_mask[INJ_BIT_A] = 1'b1;
    end
  end

  assign beat_dat = enc_blocks ^ inj_mask;

  logic             block_valid_q, block_valid_d;
  logic [BUS_W-1:0] block_q,       block_d;
  logic             skid_valid_q,  skid_valid_d;
  logic [BUS_W-1:0] skid_q,        skid_d;
  logic             accept;
  logic             consume;

  assign data_ready  = !skid_valid_q;
  assign block_valid = block_valid_q;
  assign block       = block_q;
  assign accept      = data_valid && data_ready;
  assign consume     = block_valid_q && block_ready;

  always_comb begin
    block_valid_d = block_valid_q;
    block_d       = block_q;
    skid_valid_d  = skid_valid_q;
    skid_d        = skid_q;
    if (skid_valid_q) begin
      // data_ready is low here, so only a consume can move state.
      if (consume) begin
        block_d       = skid_q;
        block_valid_d = 1'b1;
        skid_valid_d  = 1'b0;
      end
    end else if (accept) begin
      if (!block_valid_q || consume) begin
        block_d       = beat_dat;
        block_valid_d = 1'b1;
      end else begin
        skid_d       = beat_dat;
        skid_valid_d = 1'b1;
      end
    end else if (consume) begin
      block_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      block_valid_q <= 1'b0;
      block_q       <= '0;
      skid_valid_q  <= 1'b0;
      skid_q        <= '0;
    end else begin
      block_valid_q <= block_valid_d;
      block_q       <= block_d;
      skid_valid_q  <= skid_valid_d;
      skid_q        <= skid_d;
    end
  end

endmodule

// File: tb/tb_extended_hamming_stream_encoder.sv
// Self-checking bench for extended_hamming_stream_encoder (8-bit data, two lanes).
module tb_extended_hamming_stream_encoder;

  localparam int DW = 8;
  localparam int LC = 2;
  localparam int BW = 13;

  logic              clock = 1'b0;
  logic              reset;
  logic              data_valid;
  logic              data_ready;
  logic [LC*DW-1:0]  data;
  logic              inject_single;
  logic              inject_double;
  logic              block_valid;
  logic              block_ready;
  logic [LC*BW-1:0]  block;

  always #5 clock = ~clock;

  extended_hamming_stream_encoder #(.DATA_WIDTH(DW), .LANE_COUNT(LC)) dut (
    .clock         (clock),
    .reset         (reset),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .data          (data),
    .inject_single (inject_single),
    .inject_double (inject_double),
    .block_valid   (block_valid),
    .block_ready   (block_ready),
    .block         (block)
  );

  int checks = 0;
  int errors = 0;
  logic [LC*BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: walk Hamming positions, drop data into non-power-of-two slots,
  // then set each parity slot so its covered group has even parity.
  function automatic logic [BW-1:0] model_lane(input logic [DW-1:0] d);
    logic [BW-1:0] b;
    int j;
    b = '0;
    j = 0;
    for (int p = 1; p < BW; p++) begin
      if ((p & (p - 1)) != 0) begin
        b[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      for (int p = 1; p < BW; p++) begin
        if (((p & (p - 1)) != 0) && (((p >> k) & 1) == 1)) b[1 << k] = b[1 << k] ^ b[p];
      end
    end
    b[0] = ^b[BW-1:1];
    return b;
  endfunction

  function automatic logic [LC*BW-1:0] model_beat(input logic [LC*DW-1:0] d);
    logic [LC*BW-1:0] r;
    for (int l = 0; l < LC; l++) r[l*BW +: BW] = model_lane(d[l*DW +: DW]);
    return r;
  endfunction

  // Decoder view: {syndrome, overall parity}; zero for any valid codeword.
  function automatic logic [4:0] lane_syndrome(input logic [BW-1:0] b);
    logic [3:0] s;
    int p4;
    s = '0;
    for (int p = 1; p < BW; p++) begin
      p4 = p;
      if (b[p]) s = s ^ p4[3:0];
    end
    return {s, ^b};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [LC*DW-1:0] d, input logic si, input logic sd);
    data_valid    = v;
    data          = d;
    inject_single = si;
    inject_double = sd;
  endtask

  task automatic consume_check();
    logic [LC*BW-1:0] e;
    if (exp_q.size() == 0) begin
      check("rand_spurious_block", block_valid, 0);
    end else begin
      e = exp_q.pop_front();
      check("rand_order", block, e);
      for (int l = 0; l < LC; l++) check("rand_syndrome", lane_syndrome(block[l*BW +: BW]), 0);
    end
  endtask

  logic [7:0]       t_l1  [8] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0]       t_l0  [8] = '{8'h00, 8'h01, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
  logic             t_si  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic             t_sd  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [12:0]      t_e1  [8] = '{13'h0, 13'h0, 13'h0, 13'h1EEE, 13'h1EEE, 13'h1EEE, 13'h1EEE, 13'h1EEE};
  logic [12:0]      t_e0  [8] = '{13'h0, 13'h000F, 13'h1EEE, 13'h000F, 13'h000D, 13'h0009, 13'h0009, 13'h000F};

  int               acc;
  int               cyc;
  logic             stall_prev;
  logic [LC*BW-1:0] blk_prev;

  initial begin
    reset       = 1'b1;
    block_ready = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_block_valid", block_valid, 0);
    check("reset_data_ready", data_ready, 1);
    check("reset_block", block, 0);
    reset = 1'b0;

    // Directed encodings and injection, back to back at full rate.
    for (int t = 0; t < 8; t++) begin
      drive(1'b1, {t_l1[t], t_l0[t]}, t_si[t], t_sd[t]);
      tick();
      check("dir_valid", block_valid, 1);
      check("dir_block", block, {t_e1[t], t_e0[t]});
      check("dir_ready", data_ready, 1);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check("dir_drain_valid", block_valid, 0);

    // Backpressure: two beats fill output and skid, third is held off.
    block_ready = 1'b0;
    drive(1'b1, 16'h0001, 1'b0, 1'b0);
    tick();
    check("bp_first_valid", block_valid, 1);
    check("bp_first_block", block, 26'h000F);
    check("bp_first_ready", data_ready, 1);
    drive(1'b1, 16'h0002, 1'b0, 1'b0);
    tick();
    check("bp_full_ready", data_ready, 0);
    check("bp_hold_block", block, 26'h000F);
    drive(1'b1, 16'h0003, 1'b0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      tick();
      check("bp_stall_ready", data_ready, 0);
      check("bp_stall_valid", block_valid, 1);
      check("bp_stall_block", block, 26'h000F);
    end
    block_ready = 1'b1;
    tick();
    check("bp_second_block", block, model_beat(16'h0002));
    check("bp_second_ready", data_ready, 1);
    tick();
    check("bp_third_block", block, model_beat(16'h0003));
    check("bp_third_valid", block_valid, 1);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check("bp_empty_valid", block_valid, 0);

    // Random full-rate stream with random backpressure.
    acc        = 0;
    cyc        = 0;
    stall_prev = 1'b0;
    blk_prev   = '0;
    exp_q.delete();
    while (acc < 1000 && cyc < 5000) begin
      if (stall_prev) begin
        check("rand_stall_valid", block_valid, 1);
        check("rand_stall_block", block, blk_prev);
      end
      drive(1'b1, 16'($urandom), 1'b0, 1'b0);
      block_ready = ($urandom_range(0, 3) != 0);
      if (data_valid && data_ready) begin
        exp_q.push_back(model_beat(data));
        acc++;
      end
      if (block_valid && block_ready) consume_check();
      stall_prev = block_valid && !block_ready;
      blk_prev   = block;
      tick();
      cyc++;
    end
    check("rand_accepted", acc, 1000);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 50; c++) begin
      if (stall_prev) begin
        check("rand_stall_valid", block_valid, 1);
        check("rand_stall_block", block, blk_prev);
      end
      block_ready = ($urandom_range(0, 1) != 0);
      if (block_valid && block_ready) consume_check();
      stall_prev = block_valid && !block_ready;
      blk_prev   = block;
      tick();
    end
    check("rand_leftover", exp_q.size(), 0);
    check("rand_final_valid", block_valid, 0);

    // Reset with two beats buffered.
    block_ready = 1'b0;
    drive(1'b1, 16'h0011, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0022, 1'b0, 1'b0);
    tick();
    check("rst_full_ready", data_ready, 0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_valid", block_valid, 0);
    check("rst_async_ready", data_ready, 1);
    check("rst_async_block", block, 0);
    @(posedge clock);
    #1;
    reset       = 1'b0;
    block_ready = 1'b1;
    drive(1'b1, 16'h00FF, 1'b0, 1'b0);
    tick();
    check("rst_fresh_valid", block_valid, 1);
    check("rst_fresh_block", block, 26'h1EEE);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check("rst_no_stale_valid", block_valid, 0);
    check("rst_no_stale_ready", data_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
